// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and opcodes for the immediate generator
package imm_pkg;

  // Format code presented alongside each immediate
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OP_REG_32  = 7'b0111011;

  // Decoder always produces a 64-bit sign-correct immediate; narrower
  // datapaths take the low XLEN bits, which are already correctly extended.
  localparam int IMM_MAX_W = 64;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    fmt_e                 fmt;
    logic                 illegal;
  } dec_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational instruction-to-immediate decoder
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  localparam logic IS64 = (XLEN == 64);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 is_shift;
  logic [IMM_MAX_W-1:0] imm_i;
  logic [IMM_MAX_W-1:0] imm_s;
  logic [IMM_MAX_W-1:0] imm_b;
  logic [IMM_MAX_W-1:0] imm_u;
  logic [IMM_MAX_W-1:0] imm_j;
  logic [IMM_MAX_W-1:0] imm_sh;
  logic                 sh_illegal;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // shamt[5] only exists on a 64-bit datapath for full-width shifts;
  // word shifts and 32-bit datapaths treat it as a reserved encoding.
  assign imm_sh     = {58'b0, IS64 & instr[25], instr[24:20]};
  assign sh_illegal = instr[25] & (!IS64 || (opcode == OP_IMM_32));

  // Select format and immediate from the opcode
  always_comb begin
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b1;
    case (opcode)
      OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        dec.imm = imm_i; dec.fmt = FMT_I; dec.illegal = 1'b0;
      end
      OP_IMM: begin
        if (is_shift) begin
          dec.imm = imm_sh; dec.fmt = FMT_SH; dec.illegal = sh_illegal;
        end else begin
          dec.imm = imm_i; dec.fmt = FMT_I; dec.illegal = 1'b0;
        end
      end
      OP_IMM_32: begin
        if (IS64) begin
          if (is_shift) begin
            dec.imm = imm_sh; dec.fmt = FMT_SH; dec.illegal = sh_illegal;
          end else begin
            dec.imm = imm_i; dec.fmt = FMT_I; dec.illegal = 1'b0;
          end
        end
      end
      OP_STORE: begin
        dec.imm = imm_s; dec.fmt = FMT_S; dec.illegal = 1'b0;
      end
      OP_BRANCH: begin
        dec.imm = imm_b; dec.fmt = FMT_B; dec.illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm = imm_u; dec.fmt = FMT_U; dec.illegal = 1'b0;
      end
      OP_JAL: begin
        dec.imm = imm_j; dec.fmt = FMT_J; dec.illegal = 1'b0;
      end
      OP_REG: begin
        dec.fmt = FMT_R; dec.illegal = 1'b0;
      end
      OP_REG_32: begin
        if (IS64) begin
          dec.fmt = FMT_R; dec.illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with two-entry skid buffer
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  dec_t in_dec;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .dec   (in_dec)
  );

  // Main (M) entry drives the outputs; skid (K) entry absorbs one stall
  logic             m_valid;
  logic [XLEN-1:0]  m_imm;
  fmt_e             m_fmt;
  logic             m_illegal;
  logic [TAG_W-1:0] m_tag;

  logic             k_valid;
  logic [XLEN-1:0]  k_imm;
  fmt_e             k_fmt;
  logic             k_illegal;
  logic [TAG_W-1:0] k_tag;

  logic accept;
  logic m_free;

  // Ready comes only from the skid state so out_ready never reaches in_ready
  assign in_ready = rst_n & ~k_valid;
  assign accept   = in_valid & in_ready;
  assign m_free   = ~m_valid | out_ready;

  assign out_valid   = m_valid;
  assign out_imm     = m_imm;
  assign out_fmt     = m_fmt;
  assign out_illegal = m_illegal;
  assign out_tag     = m_tag;

  // Advance the M/K pair: refill M from K first to keep FIFO order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_imm     <= '0;
      m_fmt     <= FMT_NONE;
      m_illegal <= 1'b0;
      m_tag     <= '0;
      k_valid   <= 1'b0;
      k_imm     <= '0;
      k_fmt     <= FMT_NONE;
      k_illegal <= 1'b0;
      k_tag     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (m_free) begin
      if (k_valid) begin
        m_valid   <= 1'b1;
        m_imm     <= k_imm;
        m_fmt     <= k_fmt;
        m_illegal <= k_illegal;
        m_tag     <= k_tag;
        k_valid   <= 1'b0;
      end else if (accept) begin
        m_valid   <= 1'b1;
        m_imm     <= in_dec.imm[XLEN-1:0];
        m_fmt     <= in_dec.fmt;
        m_illegal <= in_dec.illegal;
        m_tag     <= in_tag;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      k_valid   <= 1'b1;
      k_imm     <= in_dec.imm[XLEN-1:0];
      k_fmt     <= in_dec.fmt;
      k_illegal <= in_dec.illegal;
      k_tag     <= in_tag;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. Accepts one 32-bit RV instruction per cycle over a valid/ready handshake. Decodes all base formats (I, S, B, U, J, shift-immediate, R/no-immediate) and outputs an XLEN-wide immediate, a format code and an illegal flag one cycle later. A two-entry skid buffer absorbs execute-stage back-pressure, and a synchronous flush discards in-flight entries on branch redirect.

## Interface
- XLEN, 64, datapath width; legal values are 32 and 64.
- TAG_W, 8, width of the sideband tag (ROB index/PC slice) carried alongside the instruction.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry present.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  sign/zero-extended immediate.
- out_fmt  out  3  format code (package enum).
- out_illegal  out  1  opcode/shamt not legal for XLEN.
- out_tag  out  TAG_W  tag of the output entry.

## Operation
- Opcode map:
  - I: 0000011, 0010011 (funct3 ≠ 001/101), 1100111, 0001111, 1110011.
  - SH: 0010011 with funct3 001/101.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011.
  - XLEN=64 only: 0011011 (I/SH) and 0111011 (R).
  - Anything else: fmt NONE, out_illegal=1, imm=0.
- Immediate bits:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - I, S, B, U and J are sign-extended from their top bit to XLEN.
- SH immediate:
  - Zero-extended shamt: instr[25:20] for XLEN=64, instr[24:20] for XLEN=32.
  - illegal=1 if instr[25]=1 with XLEN=32, or for opcode 0011011.
- R: imm=0.
- Storage: main register (M) and skid register (K), each holding {valid, imm, fmt, illegal, tag}.
- Fill rules:
  - Accept = in_valid && in_ready.
  - in_ready = !K.valid, and is forced to 0 while rst_n=0.
  - If accepting and (!M.valid or out_ready), the entry goes to M.
  - If accepting, M.valid and !out_ready, the entry goes to K.
  - On out_ready with M.valid: M ← K if K.valid, else M ← the accepted entry, else M.valid ← 0. K is cleared when it moves.
- Ordering is strict FIFO.
- Flush:
  - Both valids clear at the next edge.
  - Any input accepted in the flush cycle is dropped.
  - out_valid in the flush cycle is still presented, but the consumer must ignore it.
- Reset (asynchronous):
  - M.valid=K.valid=0, out_valid=0.
  - out_imm=0, out_fmt=NONE, out_illegal=0, out_tag=0.

## Timing
- Latency: in_valid accepted at edge N gives out_valid at N+1 with no bubble.
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- out_* are driven directly from M's registers.
- Stall: with out_ready=0, at most 2 entries are held; in_ready drops the cycle after K fills.
- Simultaneous flush and out_ready: flush wins; both registers empty.
- Reset deasserted mid-stall: the pipeline is empty and in_ready=1 on the first post-reset cycle.

## Structure
- Package imm_pkg holds:
  - The fmt enum: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, NONE=7.
  - Opcode localparams.
  - The decoded-entry struct {imm, fmt, illegal}.
- Sub-module imm_decode: purely combinational, parametrised by XLEN; instr in, struct out.
- The top-level holds only the M/K registers and handshake logic.

## Test plan
- XLEN=64, stream with out_ready=1 → each result appears on the following cycle:
  - 0xFE000EE3 (beq −4) → imm 0xFFFF_FFFF_FFFF_FFFC, fmt B.
  - 0xFF9FF06F (jal −8) → 0xFFFF_FFFF_FFFF_FFF8, fmt J.
  - 0xFE513823 (sd −16) → 0xFFFF_FFFF_FFFF_FFF0, fmt S.
- 0x123450B7 → 0x0000_0000_1234_5000 fmt U; 0x800000B7 → 0xFFFF_FFFF_8000_0000.
- 0x03F09093 (slli x1,x1,63):
  - XLEN=64 → imm 63, fmt SH, illegal=0.
  - XLEN=32 → illegal=1.
- Unknown opcode 0x0000007F → fmt NONE, imm 0, illegal=1.
- Back-pressure: send A, B, C back-to-back with out_ready=0 for 3 cycles.
  - A is held on the outputs, B sits in K, in_ready=0 so C waits.
  - Release out_ready → A, B, C are delivered in order, one per cycle.
- Flush with M and K full → out_valid=0 next cycle, in_ready=1.
- rst_n pulsed low mid-stream → all outputs at reset values immediately, with no clock edge required.
